pix_stream_tx: RTL and testbench
================================

Name: pix_stream_tx

Overview:
- Raster pixel-stream transmitter. Reads an 8-bit grayscale frame from a synchronous-read frame memory and emits it in row-major order as a valid/ready stream.
- Stream carries start-of-frame, end-of-line and end-of-frame markers, with programmable horizontal blanking between lines.
- Feeds the 5x5 line-buffered filter/threshold pipeline and any other pixel consumer in the eye-tracking datapath. It is the source end of that pixel interface.

Parameters:
- IMG_W, 256, pixels per line (>=2)
- IMG_H, 256, lines per frame (>=1)
- HBLANK, 4, idle cycles between lines (>=2)
- AW, 16, frame-memory address width (2^AW >= IMG_W*IMG_H)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low
- i_start  in  1  single-cycle frame request
- i_ready  in  1  downstream ready
- o_rd_en  out  1  memory read strobe
- o_rd_addr  out  AW  memory address, row-major y*IMG_W+x
- i_rd_data  in  8  memory data, valid exactly 1 cycle after o_rd_en
- o_pix  out  8  pixel
- o_valid  out  1  pixel valid
- o_sof  out  1  first pixel of frame (x=0,y=0)
- o_eol  out  1  last pixel of line (x=IMG_W-1)
- o_eof  out  1  last pixel of frame
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the eof beat is accepted

Behaviour:
- Reset: all outputs 0; FSM in IDLE; x/y counters 0; buffer empty. Reset takes effect immediately (async) at any point, including mid-frame.
- Beat: a transfer occurs when o_valid && i_ready.
  - Once o_valid is high, o_pix and all markers stay stable until the beat is accepted.
  - o_valid never drops without acceptance.
- FSM states: IDLE, ACTIVE, BLANK, DONE.
  - IDLE -> ACTIVE on i_start. o_busy rises the next cycle.
  - ACTIVE -> BLANK on acceptance of an eol beat that is not eof.
  - BLANK lasts exactly HBLANK cycles, then -> ACTIVE.
  - ACTIVE -> DONE on eof acceptance.
  - DONE: o_done=1 for one cycle, o_busy=0, -> IDLE.
- i_start is ignored in ACTIVE, BLANK and DONE.
- Prefetch:
  - 2-entry output buffer.
  - A read is issued only when buffered + in-flight < 2 and pixels of the current line remain.
  - Reads for line y+1 may be issued during the last 2 BLANK cycles, so latency stays hidden.
  - No read is ever issued beyond address IMG_W*IMG_H-1.
- Latency: first o_valid 2 cycles after the i_start cycle.
- Throughput: with i_ready held high, 1 pixel/cycle within a line. Gap between an eol beat and the next line's first beat is exactly HBLANK cycles.
- Backpressure: i_ready low stalls indefinitely. No pixel is dropped or duplicated, and at most 2 reads are outstanding or buffered.
- Marker order: o_sof precedes any o_eol. On the final pixel, o_eol and o_eof are both 1.
- IMG_H=1: single line. eol and eof are on the same beat; no BLANK.

Optional Feature:
- Macro PIX_STREAM_TX_TESTPAT_EN.
- Defined:
  - Adds input i_testpat (1 bit), sampled with i_start.
  - If it was 1, o_pix = (x+y) mod 256, o_rd_en stays 0, and timing and markers are identical to memory mode.
- Undefined: port absent; memory mode always.

Decomposition:
- Package pix_stream_pkg:
  - PIX_W=8
  - typedef of pixel byte
  - enum for the FSM state (IDLE/ACTIVE/BLANK/DONE)
  - beat struct {pix, sof, eol, eof}
- Sub-module pix_skid_buf: 2-entry beat FIFO with valid/ready out and push/full/count, instantiated once for the prefetch buffer.

Test Plan:
- IMG_W=4, IMG_H=2, HBLANK=2; mem[a]=a+10; i_ready=1; start pulse:
  - pixels 10,11,12,13, then 2 idle cycles, then 14,15,16,17
  - sof on 10; eol on 13 and 17; eof on 17
  - o_done one cycle after the 17 beat; o_busy low thereafter
- Same setup, i_ready alternating 1,0:
  - accepted sequence exactly 10..17
  - o_pix and markers stable on every stalled cycle
- i_ready held 0 for 6 cycles after start:
  - o_valid=1 with o_pix=10 held
  - exactly 2 o_rd_en pulses (addr 0,1) issued
- i_start pulses at the 3rd and 8th beat: ignored, frame unchanged. Then i_rst_n low mid line 1:
  - all outputs 0 asynchronously
  - the next start reads from addr 0 with o_sof
- PIX_STREAM_TX_TESTPAT_EN defined, i_testpat=1, IMG_W=4, IMG_H=2:
  - pixels 0,1,2,3 then 1,2,3,4
  - o_rd_en never asserted; markers as in the first scenario
- IMG_H=1, IMG_W=2:
  - beats 10 (sof), then 11 (eol+eof)
  - no blanking; o_done follows

Source files
------------

// File: rtl/pix_stream_pkg.sv
// Shared types for the raster pixel-stream transmitter: pixel width,
// FSM state encoding and the beat record carried through the prefetch buffer.
package pix_stream_pkg;

  localparam int PIX_W  = 8;
  localparam int BEAT_W = PIX_W + 3;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK,
    DONE
  } tx_state_t;

  typedef struct packed {
    pix_t pix;
    logic sof;
    logic eol;
    logic eof;
  } beat_t;

endpackage

// File: rtl/pix_skid_buf.sv
// Two-entry beat FIFO used as the prefetch buffer in front of the stream
// output. The head entry is held stable until it is popped by the consumer.
module pix_skid_buf
  import pix_stream_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [BEAT_W-1:0] i_data,
  output logic              o_full,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [BEAT_W-1:0] o_data,
  input  logic              i_ready
);

  logic [BEAT_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              push_ok;

  assign o_valid = (count != 2'd0);
  assign o_full  = (count == 2'd2);
  assign o_count = count;
  assign pop     = o_valid && i_ready;
  assign push_ok = i_push && (!o_full || pop);
  // Idle output reads as zero so nothing stale shows when no beat is offered
  assign o_data  = o_valid ? mem[rd_ptr] : '0;

  // Storage, pointers and occupancy; push and pop may happen in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix_stream_tx.sv
// Raster pixel-stream transmitter. Fetches an 8-bit frame from a
// synchronous-read memory in row-major order and emits it as a valid/ready
// stream with sof/eol/eof markers and HBLANK idle cycles between lines.
// Reads run ahead into a 2-entry buffer so memory latency stays hidden.
// Optional build macro PIX_STREAM_TX_TESTPAT_EN adds i_testpat, which replaces
// memory data with an (x+y) mod 256 ramp while keeping timing and markers.
module pix_stream_tx
  import pix_stream_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int HBLANK = 4,
  parameter int AW     = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_ready,
`ifdef PIX_STREAM_TX_TESTPAT_EN
  input  logic          i_testpat,
`endif
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [7:0]    i_rd_data,
  output logic [7:0]    o_pix,
  output logic          o_valid,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_busy,
  output logic          o_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  tx_state_t         state;
  logic [BW-1:0]     blank_cnt;
  logic              tp_q;
  logic              tp_start;
  logic              tp_mode;

  logic [AW-1:0]     rd_addr;
  logic [XW-1:0]     rd_x;
  logic              rd_line_done;
  logic              rd_inflight;
  logic              rd_issue;

  logic [XW-1:0]     ret_x;
  logic [YW-1:0]     ret_y;
  pix_t              tp_pix;
  beat_t             push_beat;
  beat_t             head;
  logic [BEAT_W-1:0] head_bits;
  logic [1:0]        buf_count;
  logic              buf_full;

  logic              beat;
  logic [2:0]        occ;
  logic              room;
  logic              blank_prefetch;
  logic              line_adv;
  logic              frame_end;

`ifdef PIX_STREAM_TX_TESTPAT_EN
  assign tp_start = i_testpat;
`else
  assign tp_start = 1'b0;
`endif

  assign head      = head_bits;
  assign beat      = o_valid && i_ready;
  assign line_adv  = (state == ACTIVE) && beat && head.eol && !head.eof;
  assign frame_end = (state == ACTIVE) && beat && head.eof;

  // A beat leaving this cycle frees a slot, so it counts as credit for a new read
  assign occ  = 3'(buf_count) + 3'(rd_inflight) - 3'(beat);
  assign room = (occ < 3'd2) && (!buf_full || beat);

  // Next line's first two pixels are fetched during the final two blank cycles
  assign blank_prefetch = (blank_cnt >= BW'(HBLANK - 2));

  // Test-pattern choice is taken live on the start cycle, then from the latch
  assign tp_mode   = (state == IDLE) ? tp_start : tp_q;
  assign o_rd_en   = rd_issue && !tp_mode;
  assign o_rd_addr = rd_addr;

  // Decide whether a memory read (real or virtual in test-pattern mode) goes out this cycle
  always_comb begin
    rd_issue = 1'b0;
    case (state)
      IDLE:    rd_issue = i_start;
      ACTIVE:  rd_issue = !rd_line_done && room;
      BLANK:   rd_issue = blank_prefetch && !rd_line_done && room;
      default: rd_issue = 1'b0;
    endcase
  end

  // Frame sequencing: IDLE -> ACTIVE <-> BLANK -> DONE -> IDLE, with registered busy/done
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      blank_cnt <= '0;
      tp_q      <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= ACTIVE;
            tp_q   <= tp_start;
            o_busy <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_end) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (line_adv) begin
            state     <= BLANK;
            blank_cnt <= '0;
          end
        end
        BLANK: begin
          if (blank_cnt == BW'(HBLANK - 1)) begin
            state <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-side position: address, column within the line being fetched, line-complete flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_addr      <= '0;
      rd_x         <= '0;
      rd_line_done <= 1'b0;
      rd_inflight  <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      if (state == DONE) begin
        rd_addr      <= '0;
        rd_x         <= '0;
        rd_line_done <= 1'b0;
      end else begin
        if (line_adv) rd_line_done <= 1'b0;
        if (rd_issue) begin
          rd_addr <= rd_addr + AW'(1);
          if (rd_x == XW'(IMG_W - 1)) begin
            rd_x         <= '0;
            rd_line_done <= 1'b1;
          end else begin
            rd_x <= rd_x + XW'(1);
          end
        end
      end
    end
  end

  // Return-side position: tracks which pixel each arriving datum is, for its markers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ret_x <= '0;
      ret_y <= '0;
    end else if (state == DONE) begin
      ret_x <= '0;
      ret_y <= '0;
    end else if (rd_inflight) begin
      if (ret_x == XW'(IMG_W - 1)) begin
        ret_x <= '0;
        ret_y <= ret_y + YW'(1);
      end else begin
        ret_x <= ret_x + XW'(1);
      end
    end
  end

  assign tp_pix        = PIX_W'(ret_x) + PIX_W'(ret_y);
  assign push_beat.pix = tp_q ? tp_pix : i_rd_data;
  assign push_beat.sof = (ret_x == '0) && (ret_y == '0);
  assign push_beat.eol = (ret_x == XW'(IMG_W - 1));
  assign push_beat.eof = (ret_x == XW'(IMG_W - 1)) && (ret_y == YW'(IMG_H - 1));

  pix_skid_buf u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rd_inflight),
    .i_data  (push_beat),
    .o_full  (buf_full),
    .o_count (buf_count),
    .o_valid (o_valid),
    .o_data  (head_bits),
    .i_ready (i_ready)
  );

  assign o_pix = head.pix;
  assign o_sof = head.sof;
  assign o_eol = head.eol;
  assign o_eof = head.eof;

endmodule

// File: tb/tb_pix_stream_tx.sv
// Self-checking bench for pix_stream_tx: a 4x2 instance with HBLANK=2 and a
// 2x1 instance, each fed by a behavioural memory returning addr+10.
module tb_pix_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        start, ready;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  pix;
  logic        valid, sof, eol, eof, busy, done;
`ifdef PIX_STREAM_TX_TESTPAT_EN
  logic        testpat;
`endif

  logic        start1, ready1;
  logic        rd_en1;
  logic [15:0] rd_addr1;
  logic [7:0]  rd_data1;
  logic [7:0]  pix1;
  logic        valid1, sof1, eol1, eof1, busy1, done1;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: one-cycle synchronous read returning addr+10
  always @(posedge clk) if (rd_en)  rd_data  <= 8'(rd_addr + 16'd10);
  always @(posedge clk) if (rd_en1) rd_data1 <= 8'(rd_addr1 + 16'd10);

  pix_stream_tx #(.IMG_W(4), .IMG_H(2), .HBLANK(2), .AW(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ready(ready),
`ifdef PIX_STREAM_TX_TESTPAT_EN
    .i_testpat(testpat),
`endif
    .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_pix(pix), .o_valid(valid), .o_sof(sof), .o_eol(eol), .o_eof(eof),
    .o_busy(busy), .o_done(done)
  );

  pix_stream_tx #(.IMG_W(2), .IMG_H(1), .HBLANK(2), .AW(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_ready(ready1),
`ifdef PIX_STREAM_TX_TESTPAT_EN
    .i_testpat(1'b0),
`endif
    .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
    .o_pix(pix1), .o_valid(valid1), .o_sof(sof1), .o_eol(eol1), .o_eof(eof1),
    .o_busy(busy1), .o_done(done1)
  );

  // Expected beats {pix, sof, eol, eof} for a whole frame, in stream order
  task automatic push_frame(input int w, input int h, input bit tp);
    logic [7:0] p;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        p = tp ? 8'(x + y) : 8'(y * w + x + 10);
        exp_q.push_back({p, 1'(x == 0 && y == 0), 1'(x == w - 1), 1'(x == w - 1 && y == h - 1)});
      end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, rd_addr, pix, valid, sof, eol, eof, busy, done} !== 31'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {rd_en, rd_addr, pix, valid, sof, eol, eof, busy, done});
    end
    checks++;
    if ({valid1, busy1, done1, rd_en1} !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_outputs_1x: got %b expected 0000", {valid1, busy1, done1, rd_en1});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int bc[$];
    int done_cyc = -1, done_cnt = 0, rd_cnt = 0, max_addr = 0;
    logic [10:0] exp_v, got;
    push_frame(4, 2, 0);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1; start = (c == 0); ready = 1'b1;
      @(negedge clk);
      if (rd_en) begin rd_cnt++; if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr); end
      if (c == 0) begin checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_start: got %b expected 0", busy); end end
      if (c == 1) begin checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy); end end
      if (valid && ready) begin
        bc.push_back(c);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL basic_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL basic_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (done_cyc >= 0 && c == done_cyc + 2) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
      end
    end
    start = 1'b0;
    checks++;
    if (bc.size() != 8) begin errors++; $display("[TB] FAIL basic_beat_count: got %0d expected 8", bc.size()); end
    else begin
      checks++;
      if ({bc[0], bc[3], bc[4], bc[7]} !== {32'd2, 32'd5, 32'd8, 32'd11}) begin
        errors++; $display("[TB] FAIL basic_timing: got %0d %0d %0d %0d expected 2 5 8 11", bc[0], bc[3], bc[4], bc[7]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 12) begin errors++; $display("[TB] FAIL basic_done: got count %0d cycle %0d expected 1 at 12", done_cnt, done_cyc); end
    checks++;
    if (rd_cnt != 8 || max_addr != 7) begin errors++; $display("[TB] FAIL basic_reads: got %0d reads max %0d expected 8 max 7", rd_cnt, max_addr); end
    exp_q.delete();
  endtask

  task automatic test_backpressure;
    int beats = 0, done_cnt = 0;
    logic prev_hold = 1'b0;
    logic [11:0] prev_vec, cur_vec;
    logic [10:0] exp_v, got;
    push_frame(4, 2, 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1; start = (c == 0); ready = (c % 2 == 0);
      @(negedge clk);
      cur_vec = {valid, pix, sof, eol, eof};
      if (prev_hold) begin
        checks++;
        if (cur_vec !== prev_vec) begin errors++; $display("[TB] FAIL bp_stable: got %h expected %h", cur_vec, prev_vec); end
      end
      if (valid && ready) begin
        beats++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL bp_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL bp_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) done_cnt++;
      prev_hold = valid && !ready;
      prev_vec  = cur_vec;
    end
    start = 1'b0;
    checks++;
    if (beats != 8 || done_cnt != 1) begin errors++; $display("[TB] FAIL bp_complete: got %0d beats %0d done expected 8 1", beats, done_cnt); end
    exp_q.delete();
  endtask

  task automatic test_stall;
    int early_addr[$];
    int beats = 0, done_cnt = 0;
    logic [10:0] exp_v, got;
    push_frame(4, 2, 0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1; start = (c == 0); ready = (c >= 7);
      @(negedge clk);
      if (c <= 6 && rd_en) early_addr.push_back(int'(rd_addr));
      if (c >= 2 && c <= 6) begin
        checks++;
        if (valid !== 1'b1 || pix !== 8'd10) begin errors++; $display("[TB] FAIL stall_hold: got valid %b pix %0d expected 1 10", valid, pix); end
      end
      if (valid && ready) begin
        beats++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL stall_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL stall_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (early_addr.size() != 2) begin errors++; $display("[TB] FAIL stall_reads: got %0d reads expected 2", early_addr.size()); end
    else begin
      checks++;
      if (early_addr[0] != 0 || early_addr[1] != 1) begin errors++; $display("[TB] FAIL stall_addr: got %0d %0d expected 0 1", early_addr[0], early_addr[1]); end
    end
    checks++;
    if (beats != 8 || done_cnt != 1) begin errors++; $display("[TB] FAIL stall_complete: got %0d beats %0d done expected 8 1", beats, done_cnt); end
    exp_q.delete();
  endtask

  task automatic test_start_ignored;
    int beats = 0, done_cnt = 0, rd_cnt = 0;
    logic [10:0] exp_v, got;
    push_frame(4, 2, 0);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1; start = (c == 0) || (beats == 2) || (beats == 7); ready = 1'b1;
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (valid && ready) begin
        beats++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL ign_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL ign_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (beats != 8 || done_cnt != 1 || rd_cnt != 8) begin
      errors++; $display("[TB] FAIL ign_frame: got %0d beats %0d done %0d reads expected 8 1 8", beats, done_cnt, rd_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int beats = 0, done_cnt = 0;
    bit seen_rd = 0, hit = 0;
    logic [10:0] exp_v, got;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #1; start = (c == 0); ready = 1'b1;
      @(negedge clk);
      if (valid && ready) beats++;
      if (beats == 5) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr, pix, valid, sof, eol, eof, busy, done} !== 31'd0) begin
          errors++; $display("[TB] FAIL async_reset: got %h expected 0", {rd_en, rd_addr, pix, valid, sof, eol, eof, busy, done});
        end
        hit = 1;
      end
    end
    start = 1'b0;
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL reset_point: got %0d beats expected 5", beats); rst_n = 1'b0; end
    @(negedge clk); rst_n = 1'b1;
    beats = 0;
    push_frame(4, 2, 0);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1; start = (c == 0); ready = 1'b1;
      @(negedge clk);
      if (rd_en && !seen_rd) begin
        seen_rd = 1; checks++;
        if (rd_addr !== 16'd0) begin errors++; $display("[TB] FAIL restart_addr: got %0d expected 0", rd_addr); end
      end
      if (valid && ready) begin
        beats++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL restart_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL restart_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (!seen_rd || beats != 8 || done_cnt != 1) begin
      errors++; $display("[TB] FAIL restart_frame: got rd %0d beats %0d done %0d expected 1 8 1", seen_rd, beats, done_cnt);
    end
    exp_q.delete();
  endtask

`ifdef PIX_STREAM_TX_TESTPAT_EN
  task automatic test_testpat;
    int bc[$];
    int done_cyc = -1, rd_cnt = 0;
    logic [10:0] exp_v, got;
    push_frame(4, 2, 1);
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1; start = (c == 0); testpat = (c == 0); ready = 1'b1;
      @(negedge clk);
      if (rd_en) rd_cnt++;
      if (valid && ready) begin
        bc.push_back(c); checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL tp_extra_beat: got pix %0d expected none", pix); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix, sof, eol, eof};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL tp_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done) done_cyc = c;
    end
    start = 1'b0; testpat = 1'b0;
    checks++;
    if (rd_cnt != 0) begin errors++; $display("[TB] FAIL tp_rd_en: got %0d reads expected 0", rd_cnt); end
    checks++;
    if (bc.size() != 8 || done_cyc != 12) begin errors++; $display("[TB] FAIL tp_timing: got %0d beats done at %0d expected 8 at 12", bc.size(), done_cyc); end
    else begin
      checks++;
      if (bc[0] != 2 || bc[4] != 8) begin errors++; $display("[TB] FAIL tp_gap: got %0d %0d expected 2 8", bc[0], bc[4]); end
    end
    exp_q.delete();
  endtask
`endif

  task automatic test_single_line;
    int bc[$];
    int done_cyc = -1, done_cnt = 0;
    logic [10:0] exp_v, got;
    push_frame(2, 1, 0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1; start1 = (c == 0); ready1 = 1'b1;
      @(negedge clk);
      if (valid1 && ready1) begin
        bc.push_back(c); checks++;
        if (exp_q.size() == 0) begin errors++; $display("[TB] FAIL line1_extra_beat: got pix %0d expected none", pix1); end
        else begin
          exp_v = exp_q.pop_front(); got = {pix1, sof1, eol1, eof1};
          if (got !== exp_v) begin errors++; $display("[TB] FAIL line1_beat: got %h expected %h", got, exp_v); end
        end
      end
      if (done1) begin done_cnt++; done_cyc = c; end
    end
    start1 = 1'b0;
    checks++;
    if (bc.size() != 2) begin errors++; $display("[TB] FAIL line1_count: got %0d expected 2", bc.size()); end
    else begin
      checks++;
      if (bc[0] != 2 || bc[1] != 3) begin errors++; $display("[TB] FAIL line1_timing: got %0d %0d expected 2 3", bc[0], bc[1]); end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 4) begin errors++; $display("[TB] FAIL line1_done: got count %0d cycle %0d expected 1 at 4", done_cnt, done_cyc); end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
`ifdef PIX_STREAM_TX_TESTPAT_EN
    testpat = 1'b0;
`endif
    $display("[TB] starting pix_stream_tx bench");
    test_reset;
    test_basic;
    test_backpressure;
    test_stall;
    test_start_ignored;
    test_reset_mid_frame;
`ifdef PIX_STREAM_TX_TESTPAT_EN
    test_testpat;
`endif
    test_single_line;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
